uart_prog_loader: RTL

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/loader_pkg.sv | 39 +++
 rtl/uart_rx_byte.sv | 111 +++++++++++
 rtl/uart_prog_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared definitions for the UART program loader: data width,
//               default baud divisor, and the receiver/loader state encodings.
//               L_CSUM exists only when UART_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    L_LEN  = 3'd0,
    L_DATA = 3'd1,
    L_DONE = 3'd2,
    L_ERR  = 3'd3,
    L_CSUM = 3'd4
  } ld_state_t;
`else
  typedef enum logic [1:0] {
    L_LEN  = 2'd0,
    L_DATA = 2'd1,
    L_DONE = 2'd2,
    L_ERR  = 2'd3
  } ld_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver with a 2-flop input synchronizer.
//               Start bit is confirmed at mid-bit (short low glitches are
//               dropped silently); data bits are sampled LSB first, one per
//               bit period from the mid-start point.
// Ports       : clk        - clock, rising edge
//               reset_n    - asynchronous active-low reset
//               rx         - serial line, idle high, asynchronous to clk
//               byte_data  - last received byte (valid with byte_valid)
//               byte_valid - one-cycle pulse, good stop bit seen
//               frame_err  - one-cycle pulse, stop bit sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] c_half = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid;
  logic             r_frame_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_state      <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (r_rx_prev && !r_rx_sync) r_state <= RX_START;
        end
        RX_START: begin
          if (r_clk_cnt == c_half) begin
            r_clk_cnt <= '0;
            // Line back high at mid-start: treat as noise, not an error
            r_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == c_full) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == c_full) begin
            r_clk_cnt <= '0;
            r_state   <= RX_IDLE;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end else begin
              r_frame_err  <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : Receives a program image over UART: a 4-byte little-endian
//               word count N, then N little-endian 32-bit words, each written
//               out with a one-cycle wr_en at byte addresses 0, 4, 8, ...
//               Optional feature macro: UART_LOADER_CHECKSUM_EN adds a final
//               byte that must equal the XOR of all payload bytes.
// Ports       : clk      - clock, rising edge
//               reset_n  - asynchronous active-low reset
//               rx       - UART serial input (8N1)
//               data_out - assembled program word
//               address  - byte address of data_out
//               wr_en    - one-cycle write strobe
//               done     - sticky, load completed
//               error    - sticky, load aborted
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MAX_WORDS    = 16384
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .byte_data  (w_byte),
    .byte_valid (w_byte_valid),
    .frame_err  (w_frame_err)
  );

  ld_state_t             r_state;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_word_buf;   // first three bytes of the current word
  logic [31:0]           r_words_left;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_address;
  logic                  r_wr_en;
  logic                  r_done;
  logic                  r_error;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  // Word completed by the byte arriving this cycle
  logic [31:0] w_word;
  assign w_word = {w_byte, r_word_buf};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= L_LEN;
      r_byte_cnt   <= '0;
      r_word_buf   <= '0;
      r_words_left <= '0;
      r_data_out   <= '0;
      r_address    <= '0;
      r_wr_en      <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (r_wr_en) r_address <= r_address + 32'd4;

      case (r_state)
        L_LEN: begin
          if (w_frame_err) begin
            r_state <= L_ERR;
          end else if (w_byte_valid) begin
            r_word_buf <= {w_byte, r_word_buf[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;  // wraps to 0 ready for payload
            if (r_byte_cnt == 2'd3) begin
              r_words_left <= w_word;
              if (w_word == 32'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                r_state <= L_CSUM;
`else
                r_state <= L_DONE;
`endif
              end else if (w_word > c_max_words) begin
                r_state <= L_ERR;
              end else begin
                r_state <= L_DATA;
              end
            end
          end
        end
        L_DATA: begin
          if (w_frame_err) begin
            r_state <= L_ERR;
          end else if (w_byte_valid) begin
            r_word_buf <= {w_byte, r_word_buf[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ w_byte;
`endif
            if (r_byte_cnt == 2'd3) begin
              // Strobe and terminal transition share an edge so the last
              // word is always written before done can rise.
              r_data_out   <= w_word;
              r_wr_en      <= 1'b1;
              r_words_left <= r_words_left - 32'd1;
              if (r_words_left == 32'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                r_state <= L_CSUM;
`else
                r_state <= L_DONE;
`endif
              end
            end
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        L_CSUM: begin
          if (w_frame_err) begin
            r_state <= L_ERR;
          end else if (w_byte_valid) begin
            r_state <= (w_byte == r_csum) ? L_DONE : L_ERR;
          end
        end
`endif
        L_DONE:  r_done  <= 1'b1;
        L_ERR:   r_error <= 1'b1;
        default: r_state <= L_ERR;
      endcase
    end
  end

  assign data_out = r_data_out;
  assign address  = r_address;
  assign wr_en    = r_wr_en;
  assign done     = r_done;
  assign error    = r_error;

endmodule
`default_nettype wire
